// File: rtl/fpnew_noncomp_sched.sv
// Round-robin scheduler sharing one combinational non-comp FP slice among NumReq requesters.
// Define FPU_NONCOMP_SCHED_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module fpnew_noncomp_sched #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned TagWidth = 4,
  parameter int unsigned IdWidth  = $clog2(NumReq)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*2*WIDTH-1:0]    req_operands_i,
  input  logic [NumReq*4-1:0]          req_op_i,
  input  logic [NumReq*3-1:0]          req_rnd_mode_i,
  input  logic [NumReq-1:0]            req_op_mod_i,
  input  logic [NumReq*TagWidth-1:0]   req_tag_i,
  output logic                         unit_valid_o,
  output logic [2*WIDTH-1:0]           unit_operands_o,
  output logic [3:0]                   unit_op_o,
  output logic [2:0]                   unit_rnd_mode_o,
  output logic                         unit_op_mod_o,
  input  logic [WIDTH-1:0]             unit_result_i,
  input  logic [4:0]                   unit_status_i,
  input  logic                         unit_ext_i,
  input  logic [9:0]                   unit_class_mask_i,
  input  logic                         unit_is_class_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [IdWidth-1:0]           rsp_id_o,
  output logic [TagWidth-1:0]          rsp_tag_o,
  output logic [WIDTH-1:0]             rsp_result_o,
  output logic [4:0]                   rsp_status_o,
  output logic                         rsp_ext_o,
  output logic [9:0]                   rsp_class_mask_o,
  output logic                         rsp_is_class_o,
  output logic                         busy_o
);

  localparam int unsigned OpW     = 4;
  localparam int unsigned RndW    = 3;
  localparam int unsigned StatusW = 5;
  localparam int unsigned ClassW  = 10;
  localparam int unsigned OpndW   = 2 * WIDTH;

  logic                rsp_valid_q, rsp_valid_d;
  logic [IdWidth-1:0]  rsp_id_q, rsp_id_d;
  logic [TagWidth-1:0] rsp_tag_q, rsp_tag_d;
  logic [WIDTH-1:0]    rsp_result_q, rsp_result_d;
  logic [StatusW-1:0]  rsp_status_q, rsp_status_d;
  logic                rsp_ext_q, rsp_ext_d;
  logic [ClassW-1:0]   rsp_class_mask_q, rsp_class_mask_d;
  logic                rsp_is_class_q, rsp_is_class_d;

  logic                grant_en;
  logic                found;
  logic                grant;
  logic [IdWidth-1:0]  gnt_idx;

`ifndef FPU_NONCOMP_SCHED_FIXED_PRIO_EN
  logic [IdWidth-1:0]  rr_q, rr_d;
`endif

  // Arbitration: search from the pointer (or index 0), wrapping modulo NumReq.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    found    = 1'b0;
    gnt_idx  = '0;
    grant_en = ~rst_i & ~flush_i & (~rsp_valid_q | rsp_ready_i);
    for (int unsigned i = 0; i < NumReq; i++) begin
`ifdef FPU_NONCOMP_SCHED_FIXED_PRIO_EN
      cand = i;
`else
      cand = 32'(rr_q) + i;
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
`endif
      if (!found && req_valid_i[IdWidth'(cand)]) begin
        found   = 1'b1;
        gnt_idx = IdWidth'(cand);
      end
    end
    grant = grant_en & found;
  end

  // One-hot accept towards the requesters.
  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

`ifndef FPU_NONCOMP_SCHED_FIXED_PRIO_EN
  always_comb begin
    rr_d = rr_q;
    if (grant) begin
      rr_d = (gnt_idx == IdWidth'(NumReq - 1)) ? '0 : gnt_idx + IdWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Drive the shared unit with the granted request; zeros when idle.
  always_comb begin
    int unsigned sel;
    sel             = 32'(gnt_idx);
    unit_valid_o    = 1'b0;
    unit_operands_o = '0;
    unit_op_o       = '0;
    unit_rnd_mode_o = '0;
    unit_op_mod_o   = 1'b0;
    if (grant) begin
      unit_valid_o    = 1'b1;
      unit_operands_o = req_operands_i[sel*OpndW +: OpndW];
      unit_op_o       = req_op_i[sel*OpW +: OpW];
      unit_rnd_mode_o = req_rnd_mode_i[sel*RndW +: RndW];
      unit_op_mod_o   = req_op_mod_i[gnt_idx];
    end
  end

  // Response register: load on grant, drop on flush, clear on drain.
  always_comb begin
    rsp_valid_d      = rsp_valid_q;
    rsp_id_d         = rsp_id_q;
    rsp_tag_d        = rsp_tag_q;
    rsp_result_d     = rsp_result_q;
    rsp_status_d     = rsp_status_q;
    rsp_ext_d        = rsp_ext_q;
    rsp_class_mask_d = rsp_class_mask_q;
    rsp_is_class_d   = rsp_is_class_q;
    if (flush_i) begin
      rsp_valid_d = 1'b0;
    end else if (grant) begin
      rsp_valid_d      = 1'b1;
      rsp_id_d         = gnt_idx;
      rsp_tag_d        = req_tag_i[32'(gnt_idx)*TagWidth +: TagWidth];
      rsp_result_d     = unit_result_i;
      rsp_status_d     = unit_status_i;
      rsp_ext_d        = unit_ext_i;
      rsp_class_mask_d = unit_class_mask_i;
      rsp_is_class_d   = unit_is_class_i;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q      <= 1'b0;
      rsp_id_q         <= '0;
      rsp_tag_q        <= '0;
      rsp_result_q     <= '0;
      rsp_status_q     <= '0;
      rsp_ext_q        <= 1'b0;
      rsp_class_mask_q <= '0;
      rsp_is_class_q   <= 1'b0;
    end else begin
      rsp_valid_q      <= rsp_valid_d;
      rsp_id_q         <= rsp_id_d;
      rsp_tag_q        <= rsp_tag_d;
      rsp_result_q     <= rsp_result_d;
      rsp_status_q     <= rsp_status_d;
      rsp_ext_q        <= rsp_ext_d;
      rsp_class_mask_q <= rsp_class_mask_d;
      rsp_is_class_q   <= rsp_is_class_d;
    end
  end

  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_id_o         = rsp_id_q;
  assign rsp_tag_o        = rsp_tag_q;
  assign rsp_result_o     = rsp_result_q;
  assign rsp_status_o     = rsp_status_q;
  assign rsp_ext_o        = rsp_ext_q;
  assign rsp_class_mask_o = rsp_class_mask_q;
  assign rsp_is_class_o   = rsp_is_class_q;
  assign busy_o           = rsp_valid_q;

endmodule
